// File: rtl/srdl_intr_reg_if.sv
// ============================================================================
//  Module      : srdl_intr_reg_if
//  Description : Software access bus for the interrupt register block.
//                The master drives access/strobe/address/write data. The
//                slave returns registered read data and a read-valid pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface srdl_intr_reg_if #(
    parameter int WIDTH = 8
);
    logic             acc;
    logic             rd;
    logic             wr;
    logic [1:0]       sw_addr;
    logic [WIDTH-1:0] sw_wdata;
    logic [WIDTH-1:0] sw_rdata;
    logic             rd_valid;

    modport master (
        output acc, rd, wr, sw_addr, sw_wdata,
        input  sw_rdata, rd_valid
    );

    modport slave (
        input  acc, rd, wr, sw_addr, sw_wdata,
        output sw_rdata, rd_valid
    );
endinterface

`default_nettype wire

// File: rtl/srdl_intr_reg.sv
// ============================================================================
//  Module      : srdl_intr_reg
//  Description : Interrupt status register block. Each source bit can be
//                level, rising, falling or any-edge detected. The block has
//                a sticky STATUS register (write-1-to-clear), an ENABLE mask,
//                a TEST set port and a saturating event counter. It drives a
//                registered irq with an optional low-time holdoff.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module srdl_intr_reg #(
    parameter int                   WIDTH        = 8,
    parameter logic [2*WIDTH-1:0]   MODE         = '0,
    parameter logic [WIDTH-1:0]     ENABLE_RESET = '1,
    parameter int                   HOLDOFF      = 0,
    parameter int                   CNTW         = 8
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic [WIDTH-1:0] hw_in_i,
    srdl_intr_reg_if.slave        bus,
    output logic                  irq_o,
    output logic [WIDTH-1:0]      status_o
);

    // Holdoff counter must be at least one bit wide even when HOLDOFF is 0.
    localparam int              HOLDW       = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
    localparam logic [HOLDW-1:0] c_HOLD_LOAD = HOLDW'(HOLDOFF);
    localparam logic [CNTW-1:0]  c_CNT_MAX   = '1;

    localparam logic [1:0] c_ADDR_STATUS = 2'd0;
    localparam logic [1:0] c_ADDR_ENABLE = 2'd1;
    localparam logic [1:0] c_ADDR_TEST   = 2'd2;
    localparam logic [1:0] c_ADDR_COUNT  = 2'd3;

    logic [WIDTH-1:0] hw_q;
    logic [WIDTH-1:0] status_q,   status_d;
    logic [WIDTH-1:0] enable_q,   enable_d;
    logic [WIDTH-1:0] sw_rdata_q, sw_rdata_d;
    logic [CNTW-1:0]  count_q,    count_d;
    logic [HOLDW-1:0] hold_q,     hold_d;
    logic             irq_q,      irq_d;
    logic             rd_valid_q, rd_valid_d;

    logic [WIDTH-1:0] w_event;
    logic [WIDTH-1:0] w_clr;
    logic [WIDTH-1:0] w_tset;
    logic [WIDTH-1:0] w_cnt_rd;
    logic [WIDTH-1:0] w_rd_mux;
    logic             w_wr_en;
    logic             w_rd_en;

    assign w_wr_en = bus.acc & bus.wr;
    assign w_rd_en = bus.acc & bus.rd;

    // Per-bit event detection; the mode of each bit is fixed at elaboration.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_evt
            localparam logic [1:0] c_MODE = MODE[2*gi +: 2];
            assign w_event[gi] =
                (c_MODE == 2'b00) ? hw_in_i[gi] :
                (c_MODE == 2'b01) ? (hw_in_i[gi] & ~hw_q[gi]) :
                (c_MODE == 2'b10) ? (~hw_in_i[gi] & hw_q[gi]) :
                                    (hw_in_i[gi] ^ hw_q[gi]);
        end
    endgenerate

    // COUNT is presented zero-extended, or truncated when wider than the bus.
    generate
        if (CNTW >= WIDTH) begin : g_cnt_trunc
            assign w_cnt_rd = count_q[WIDTH-1:0];
        end else begin : g_cnt_ext
            assign w_cnt_rd = {{(WIDTH-CNTW){1'b0}}, count_q};
        end
    endgenerate

    // Next-state logic for registers, counter, read path and irq holdoff.
    always_comb begin
        w_clr      = (w_wr_en && bus.sw_addr == c_ADDR_STATUS) ? bus.sw_wdata : '0;
        w_tset     = (w_wr_en && bus.sw_addr == c_ADDR_TEST)   ? bus.sw_wdata : '0;

        // Event and test-set are OR-ed after the clear, so set wins.
        status_d   = (status_q & ~w_clr) | w_event | w_tset;

        enable_d   = (w_wr_en && bus.sw_addr == c_ADDR_ENABLE) ? bus.sw_wdata : enable_q;

        count_d    = count_q;
        if (w_wr_en && bus.sw_addr == c_ADDR_COUNT) begin
            count_d = '0;
        end else if ((|(w_event & enable_q)) && (count_q != c_CNT_MAX)) begin
            count_d = count_q + CNTW'(1);
        end

        case (bus.sw_addr)
            c_ADDR_STATUS: w_rd_mux = status_q;
            c_ADDR_ENABLE: w_rd_mux = enable_q;
            c_ADDR_TEST:   w_rd_mux = '0;
            default:       w_rd_mux = w_cnt_rd;
        endcase
        sw_rdata_d = w_rd_en ? w_rd_mux : sw_rdata_q;
        rd_valid_d = w_rd_en;

        irq_d      = (|(status_q & enable_q)) && (hold_q == '0);

        hold_d     = hold_q;
        if (irq_q && !irq_d) begin
            hold_d = c_HOLD_LOAD;
        end else if (hold_q != '0) begin
            hold_d = hold_q - HOLDW'(1);
        end
    end

    // State registers with synchronous reset overriding all bus activity.
    always_ff @(posedge clk) begin
        if (rst) begin
            hw_q       <= '0;
            status_q   <= '0;
            enable_q   <= ENABLE_RESET;
            count_q    <= '0;
            hold_q     <= '0;
            irq_q      <= 1'b0;
            sw_rdata_q <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            hw_q       <= hw_in_i;
            status_q   <= status_d;
            enable_q   <= enable_d;
            count_q    <= count_d;
            hold_q     <= hold_d;
            irq_q      <= irq_d;
            sw_rdata_q <= sw_rdata_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign bus.sw_rdata = sw_rdata_q;
    assign bus.rd_valid = rd_valid_q;
    assign irq_o        = irq_q;
    assign status_o     = status_q;

endmodule

`default_nettype wire
